// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: FSM state, buffered entry layout, fetch stride.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifu_pkg;

    localparam int IFU_ADDR_W  = 64;
    localparam int IFU_INSTR_W = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } ifu_state_t;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0]  pc;
        logic [IFU_INSTR_W-1:0] data;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// DEPTH-entry {pc, data} FIFO with synchronous flush, occupancy count and flop-sourced head.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens the same cycle; flush beats push/pop.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  ifu_entry_t    push_entry,
    input  logic          pop,
    output ifu_entry_t    head,
    output logic [CW-1:0] count,
    output logic          empty
);

    ifu_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch: credit-limited imem requests, {pc,data} buffering, redirect flush.
// Latency: response to instr_* in 1 cycle; request issues in the cycle after a redirect if nothing is in flight.
// Backpressure: requests stop when buffered + in-flight reach DEPTH; optional IFU_PERF_CNT_EN adds perf_stall_cnt.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int                ADDR_W       = IFU_ADDR_W,
    parameter int                INSTR_W      = IFU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 64'd0,
    parameter int                DEPTH        = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    ifu_state_t        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] target_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     drop_nxt;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       in_use;
    logic [ADDR_W-1:0] tag_q [DEPTH];
    logic [PW-1:0]     tag_wr;
    logic [PW-1:0]     tag_rd;
    logic              req_fire;
    logic              rsp_take;
    logic              pop_fire;
    logic              fifo_empty;
    ifu_entry_t        push_entry;
    ifu_entry_t        fifo_head;

    function automatic logic [PW-1:0] tag_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign target_pc     = redirect_pc & ~ADDR_W'(INSTR_BYTES - 1);
    assign imem_req_addr = fetch_pc;
    assign instr_valid   = !fifo_empty;
    assign instr_pc      = fifo_head.pc;
    assign instr_data    = fifo_head.data;

    // The slot freed by this cycle's pop counts as credit, so a 1-cycle memory streams at full rate
    // while buffered + in-flight still never exceeds DEPTH after the edge.
    always_comb begin
        pop_fire       = instr_valid && instr_ready && !redirect_valid;
        in_use         = {1'b0, fifo_count} + {1'b0, outstanding} - {{CW{1'b0}}, pop_fire};
        imem_req_valid = reset && (state == FETCH) && !redirect_valid && (in_use < DEPTH_C);
        req_fire       = imem_req_valid && imem_req_ready;
        rsp_take       = imem_rsp_valid && (state == FETCH) && (outstanding != '0);
        push_entry     = '{pc: tag_q[tag_rd], data: imem_rsp_data};
        drop_nxt       = drop_cnt;
        if (state == FETCH) begin
            drop_nxt = outstanding - CW'(rsp_take);
        end else if (imem_rsp_valid && (drop_cnt != '0)) begin
            drop_nxt = drop_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_VECTOR;
            outstanding <= '0;
            drop_cnt    <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (redirect_valid) begin
                        fetch_pc    <= target_pc;
                        outstanding <= '0;
                        tag_wr      <= '0;
                        tag_rd      <= '0;
                        drop_cnt    <= drop_nxt;
                        state       <= (drop_nxt != '0) ? FLUSH : FETCH;
                    end else begin
                        if (req_fire) begin
                            tag_q[tag_wr] <= fetch_pc;
                            tag_wr        <= tag_inc(tag_wr);
                            fetch_pc      <= fetch_pc + ADDR_W'(INSTR_BYTES);
                        end
                        if (rsp_take) begin
                            tag_rd <= tag_inc(tag_rd);
                        end
                        case ({req_fire, rsp_take})
                            2'b10:   outstanding <= outstanding + 1'b1;
                            2'b01:   outstanding <= outstanding - 1'b1;
                            default: outstanding <= outstanding;
                        endcase
                    end
                end
                FLUSH: begin
                    // A second redirect only retargets; the stale responses still have to drain.
                    drop_cnt <= drop_nxt;
                    if (redirect_valid) begin
                        fetch_pc <= target_pc;
                    end
                    if (drop_nxt == '0) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    ifu_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (rsp_take && !redirect_valid),
        .push_entry (push_entry),
        .pop        (pop_fire),
        .head       (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
        end else if (!instr_valid && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: variable-latency memory model, directed scenarios,
// expected {pc,data} queue checked by an independent delivery monitor.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [63:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents: upper half is the low address bits, lower half their complement.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // ---------------- memory model ----------------
    logic        mem_ready = 1'b1;
    int          mem_lat = 1;
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    logic [63:0] req_addr_log[$];
    int          req_cyc_log[$];
    logic [63:0] tmp_addr;
    int          tmp_due;

    assign imem_req_ready = mem_ready;

    always @(negedge clk) begin
        #1;
        if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            tmp_addr       = pend_addr.pop_front();
            tmp_due        = pend_due.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(tmp_addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + mem_lat);
            req_addr_log.push_back(imem_req_addr);
            req_cyc_log.push_back(cyc);
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [63:0] exp_pc[$];
    logic [31:0] exp_dat[$];
    int          delivered = 0;
    logic [63:0] mon_pc;
    logic [31:0] mon_dat;

    always @(negedge clk) begin
        #3;
        if (reset && instr_valid && instr_ready && !redirect_valid) begin
            delivered++;
            if (exp_pc.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got pc 0x%0h data 0x%0h, expected none", instr_pc, instr_data);
            end else begin
                mon_pc  = exp_pc.pop_front();
                mon_dat = exp_dat.pop_front();
                check64("instr_pc", instr_pc, mon_pc);
                check64("instr_data", 64'(instr_data), 64'(mon_dat));
            end
        end
    end

    task automatic push_one(input logic [63:0] pc, input logic [31:0] dat);
        exp_pc.push_back(pc);
        exp_dat.push_back(dat);
    endtask

    task automatic push_path(input logic [63:0] base, input int n);
        logic [63:0] pc;
        pc = base;
        for (int i = 0; i < n; i++) begin
            push_one(pc, mem_word(pc));
            pc = pc + 64'd4;
        end
    endtask

    task automatic do_reset(input int lat);
        @(negedge clk);
        reset          = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ready      = 1'b1;
        repeat (5) @(negedge clk);
        mem_lat = lat;
        exp_pc.delete();
        exp_dat.delete();
        req_addr_log.delete();
        req_cyc_log.delete();
        delivered = 0;
    endtask

    function automatic logic [63:0] log_addr(input int i);
        if (req_addr_log.size() > i) return req_addr_log[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int rel;
    int red_cyc;
    int first_valid;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_snap;
`endif

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        check64("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check64("rst_req_addr", imem_req_addr, 64'd0);
        check64("rst_instr_valid", 64'(instr_valid), 64'd0);
        check64("rst_instr_data", 64'(instr_data), 64'd0);
        check64("rst_instr_pc", instr_pc, 64'd0);

        // Streaming with 1-cycle memory
        do_reset(1);
        push_path(64'h0, 40);
        instr_ready = 1'b1;
        reset       = 1'b1;
        rel         = cyc;
        #4;
        check64("t1_first_req_valid", 64'(imem_req_valid), 64'd1);
        check64("t1_first_req_addr", imem_req_addr, 64'h0);
        first_valid = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            #4;
            if (instr_valid && first_valid < 0) first_valid = cyc - rel;
        end
        check64("t1_first_valid_lat", 64'(first_valid), 64'd2);
        check64("t1_req0", log_addr(0), 64'h0);
        check64("t1_req1", log_addr(1), 64'h4);
        check64("t1_req2", log_addr(2), 64'h8);
        check64("t1_req3", log_addr(3), 64'hC);
        check64("t1_throughput", 64'(delivered), 64'd13);

        // Decode stall: credits cap in-flight plus buffered at DEPTH
        do_reset(1);
        push_path(64'h0, 40);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #4;
        check64("t2_req_count", 64'(req_addr_log.size()), 64'd2);
        check64("t2_head_valid", 64'(instr_valid), 64'd1);
        check64("t2_head_pc", instr_pc, 64'h0);
        @(negedge clk);
        instr_ready = 1'b1;
        repeat (9) @(negedge clk);
        #4;
        check64("t2_delivered", 64'(delivered), 64'd10);

        // Redirect with two requests in flight, 3-cycle memory
        do_reset(3);
        instr_ready = 1'b1;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h1003;
        exp_pc.delete();
        exp_dat.delete();
        push_path(64'h1000, 20);
        red_cyc = cyc;
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check64("t3_valid_after_redirect", 64'(instr_valid), 64'd0);
        repeat (12) @(negedge clk);
        #4;
        check64("t3_new_req_addr", log_addr(2), 64'h1000);
        check64("t3_new_req_cycle", 64'((req_cyc_log.size() > 2) ? req_cyc_log[2] - red_cyc : -1), 64'd3);
        check64("t3_delivered_some", 64'(delivered > 0), 64'd1);

        // Redirect coinciding with a response and a pop
        do_reset(1);
        instr_ready = 1'b1;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        exp_pc.delete();
        exp_dat.delete();
        push_path(64'h2000, 40);
        #4;
        check64("t4_rsp_coincides", 64'(imem_rsp_valid), 64'd1);
        check64("t4_pop_coincides", 64'(instr_valid), 64'd1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        check64("t4_fifo_empty", 64'(instr_valid), 64'd0);
        check64("t4_req_valid", 64'(imem_req_valid), 64'd1);
        check64("t4_req_addr", imem_req_addr, 64'h2000);
        repeat (8) @(negedge clk);
        #4;
        check64("t4_delivered", 64'(delivered), 64'd7);

        // Address wrap at the top of the space
        do_reset(1);
        push_one(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFC_0003);
        push_one(64'h0, 32'h0000_FFFF);
        push_one(64'h4, 32'h0004_FFFB);
        push_path(64'h8, 10);
        instr_ready    = 1'b1;
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (7) @(negedge clk);
        #4;
        check64("t5_req_top", log_addr(0), 64'hFFFF_FFFF_FFFF_FFFC);
        check64("t5_req_wrap", log_addr(1), 64'h0);
        check64("t5_delivered", 64'(delivered), 64'd6);

        // Asynchronous reset mid-flight; stale responses must be ignored
        do_reset(3);
        instr_ready = 1'b1;
        reset       = 1'b1;
        repeat (2) @(negedge clk);
        #4;
        check64("t6_pc_advanced", imem_req_addr, 64'h8);
        reset = 1'b0;
        #1;
        check64("t6_async_req_addr", imem_req_addr, 64'h0);
        check64("t6_async_req_valid", 64'(imem_req_valid), 64'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        reset     = 1'b1;
        exp_pc.delete();
        exp_dat.delete();
        push_path(64'h0, 20);
        repeat (2) @(negedge clk);
        #4;
        check64("t6_stale_ignored", 64'(instr_valid), 64'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        repeat (9) @(negedge clk);
        #4;
        check64("t6_delivered_some", 64'(delivered >= 2), 64'd1);

`ifdef IFU_PERF_CNT_EN
        do_reset(1);
        mem_ready = 1'b0;
        reset     = 1'b1;
        repeat (5) @(negedge clk);
        #4;
        check64("perf_stall_min", 64'(perf_stall_cnt >= 32'd5), 64'd1);
        @(negedge clk);
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #4;
        perf_snap = perf_stall_cnt;
        check64("perf_valid_held", 64'(instr_valid), 64'd1);
        repeat (4) @(negedge clk);
        #4;
        check64("perf_frozen", 64'(perf_stall_cnt), 64'(perf_snap));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
